// File: rtl/pipe_stage_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Control vectors are packed as {pc_en, en[3:0], flush[3:0]}, where bit 0 is the s1_s2 latch and bit 3 is s4_s5.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MC_WAIT = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  localparam int STALL_CNT_W_DEF = 16;
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic       pc_en;
    logic [3:0] en;
    logic [3:0] flush;
  } ctrl_t;

  localparam ctrl_t CTRL_BOOT = '{pc_en: 1'b0, en: 4'b0000, flush: 4'b1111};
  localparam ctrl_t CTRL_RUN  = '{pc_en: 1'b1, en: 4'b1111, flush: 4'b0000};
  localparam ctrl_t CTRL_FRZ  = '{pc_en: 1'b0, en: 4'b0000, flush: 4'b0000};
  localparam ctrl_t CTRL_MEM  = '{pc_en: 1'b0, en: 4'b0000, flush: 4'b1000};
  localparam ctrl_t CTRL_BR   = '{pc_en: 1'b1, en: 4'b1100, flush: 4'b0011};
  localparam ctrl_t CTRL_MC   = '{pc_en: 1'b0, en: 4'b1000, flush: 4'b0100};
  localparam ctrl_t CTRL_LU   = '{pc_en: 1'b0, en: 4'b1100, flush: 4'b0010};

  // Only RUN and MC_WAIT cycles that hold the PC count as pipeline stalls.
  function automatic logic is_counted_stall(input state_t st, input ctrl_t c);
    return ((st == ST_RUN) || (st == ST_MC_WAIT)) && !c.pc_en;
  endfunction

endpackage

// File: rtl/pipe_stage_ctrl_load_use.sv
// Load-use hazard detector: the load in EX produces a register the ID instruction reads.
// Writes to x0 never create a dependency.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  output logic       hazard
);

  logic w_rs1_dep;
  logic w_rs2_dep;
  logic w_rd_live;

  assign w_rd_live = ex_is_load && (ex_rd != REG_X0);
  assign w_rs1_dep = id_uses_rs1 && (id_rs1 == ex_rd);
  assign w_rs2_dep = id_uses_rs2 && (id_rs2 == ex_rd);
  assign hazard    = w_rd_live && (w_rs1_dep || w_rs2_dep);

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: folds memory stalls, branches,
// multi-cycle EX ops, load-use hazards and debug halt into one per-cycle control vector.
module pipe_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_MAX_CYCLES = 34,
  parameter int STALL_CNT_W   = STALL_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_is_load,
  input  logic                   branch_taken,
  input  logic                   mc_start,
  input  logic                   mc_done,
  input  logic                   mem_stall,
  input  logic                   halt_req,
  input  logic                   resume,
  output logic                   pc_en,
  output logic                   en_s1_s2,
  output logic                   en_s2_s3,
  output logic                   en_s3_s4,
  output logic                   en_s4_s5,
  output logic                   flush_s1_s2,
  output logic                   flush_s2_s3,
  output logic                   flush_s3_s4,
  output logic                   flush_s4_s5,
  output logic [1:0]             state_out,
  output logic                   mc_timeout,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int MC_CNT_W = $clog2(MC_MAX_CYCLES + 1);
  localparam logic [MC_CNT_W-1:0] MC_LIMIT = MC_CNT_W'(MC_MAX_CYCLES);

  state_t                r_state;
  logic [MC_CNT_W-1:0]   r_mc_cnt;
  logic                  r_mc_timeout;
  logic [STALL_CNT_W-1:0] r_stall_count;

  state_t                w_state_nxt;
  logic [MC_CNT_W-1:0]   w_mc_cnt_nxt;
  logic                  w_timeout_set;
  ctrl_t                 w_ctrl;
  logic                  w_hazard;
  logic                  w_stall;

  load_use_detect u_load_use (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .hazard      (w_hazard)
  );

  // Control vector is combinational on current inputs so stalls/flushes act this cycle.
  always_comb begin
    w_ctrl        = CTRL_FRZ;
    w_state_nxt   = r_state;
    w_mc_cnt_nxt  = r_mc_cnt;
    w_timeout_set = 1'b0;
    unique case (r_state)
      ST_BOOT: begin
        w_ctrl      = CTRL_BOOT;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (mem_stall) begin
          w_ctrl = CTRL_MEM;
        end else if (branch_taken) begin
          w_ctrl = CTRL_BR;
        end else if (mc_start && !mc_done) begin
          w_ctrl       = CTRL_MC;
          w_state_nxt  = ST_MC_WAIT;
          w_mc_cnt_nxt = MC_CNT_W'(1);
        end else if (w_hazard) begin
          w_ctrl = CTRL_LU;
        end else if (halt_req) begin
          w_ctrl      = CTRL_FRZ;
          w_state_nxt = ST_HALTED;
        end else begin
          w_ctrl = CTRL_RUN;
        end
      end
      ST_MC_WAIT: begin
        // Branch, halt and load-use cannot occur meaningfully while EX is occupied.
        if (mem_stall) begin
          w_ctrl = CTRL_MEM;
        end else if (mc_done) begin
          w_ctrl       = CTRL_RUN;
          w_state_nxt  = ST_RUN;
          w_mc_cnt_nxt = '0;
        end else if (r_mc_cnt == MC_LIMIT) begin
          w_ctrl        = CTRL_RUN;
          w_state_nxt   = ST_RUN;
          w_mc_cnt_nxt  = '0;
          w_timeout_set = 1'b1;
        end else begin
          w_ctrl       = CTRL_MC;
          w_mc_cnt_nxt = r_mc_cnt + MC_CNT_W'(1);
        end
      end
      ST_HALTED: begin
        w_ctrl = CTRL_FRZ;
        if (resume) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_ctrl      = CTRL_BOOT;
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  assign w_stall = is_counted_stall(r_state, w_ctrl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_BOOT;
      r_mc_cnt      <= '0;
      r_mc_timeout  <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
      if (w_timeout_set) begin
        r_mc_timeout <= 1'b1;
      end
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + STALL_CNT_W'(1);
      end
    end
  end

  assign pc_en       = w_ctrl.pc_en;
  assign en_s1_s2    = w_ctrl.en[0];
  assign en_s2_s3    = w_ctrl.en[1];
  assign en_s3_s4    = w_ctrl.en[2];
  assign en_s4_s5    = w_ctrl.en[3];
  assign flush_s1_s2 = w_ctrl.flush[0];
  assign flush_s2_s3 = w_ctrl.flush[1];
  assign flush_s3_s4 = w_ctrl.flush[2];
  assign flush_s4_s5 = w_ctrl.flush[3];
  assign state_out   = r_state;
  assign mc_timeout  = r_mc_timeout;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl: each step drives one cycle of inputs, queues the
// expected control vector/state/counters, then pops and checks them before the next edge.
module tb_pipe_stage_ctrl;

  localparam int TB_MC_MAX = 6;
  localparam int SCW       = 16;

  // Expected vectors, ordered {pc_en, en12, en23, en34, en45, fl12, fl23, fl34, fl45}
  localparam logic [8:0] C_BOOT = 9'b0_0000_1111;
  localparam logic [8:0] C_RUN  = 9'b1_1111_0000;
  localparam logic [8:0] C_FRZ  = 9'b0_0000_0000;
  localparam logic [8:0] C_MEM  = 9'b0_0000_0001;
  localparam logic [8:0] C_BR   = 9'b1_0011_1100;
  localparam logic [8:0] C_MC   = 9'b0_0001_0010;
  localparam logic [8:0] C_LU   = 9'b0_0011_0100;

  logic           clk;
  logic           rst;
  logic [4:0]     id_rs1, id_rs2, ex_rd;
  logic           id_uses_rs1, id_uses_rs2, ex_is_load;
  logic           branch_taken, mc_start, mc_done, mem_stall, halt_req, resume;
  logic           pc_en, en_s1_s2, en_s2_s3, en_s3_s4, en_s4_s5;
  logic           flush_s1_s2, flush_s2_s3, flush_s3_s4, flush_s4_s5;
  logic [1:0]     state_out;
  logic           mc_timeout;
  logic [SCW-1:0] stall_count;
  logic [8:0]     obs_ctl;

  typedef struct {
    string          tag;
    logic [8:0]     ctl;
    logic [1:0]     st;
    logic [SCW-1:0] sc;
    logic           to;
  } exp_t;

  exp_t           q[$];
  int             n_assert = 0;
  int             n_fail   = 0;
  logic [SCW-1:0] sc_model = '0;
  logic           to_model = 1'b0;

  pipe_stage_ctrl #(
    .MC_MAX_CYCLES (TB_MC_MAX),
    .STALL_CNT_W   (SCW)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .branch_taken (branch_taken),
    .mc_start     (mc_start),
    .mc_done      (mc_done),
    .mem_stall    (mem_stall),
    .halt_req     (halt_req),
    .resume       (resume),
    .pc_en        (pc_en),
    .en_s1_s2     (en_s1_s2),
    .en_s2_s3     (en_s2_s3),
    .en_s3_s4     (en_s3_s4),
    .en_s4_s5     (en_s4_s5),
    .flush_s1_s2  (flush_s1_s2),
    .flush_s2_s3  (flush_s2_s3),
    .flush_s3_s4  (flush_s3_s4),
    .flush_s4_s5  (flush_s4_s5),
    .state_out    (state_out),
    .mc_timeout   (mc_timeout),
    .stall_count  (stall_count)
  );

  assign obs_ctl = {pc_en, en_s1_s2, en_s2_s3, en_s3_s4, en_s4_s5,
                    flush_s1_s2, flush_s2_s3, flush_s3_s4, flush_s4_s5};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_ins();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_is_load = 1'b0;
    branch_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
    mem_stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic check_out();
    exp_t e;
    if (q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard: output seen with queue size=%0d, required >0", q.size());
    end else begin
      e = q.pop_front();
      n_assert++;
      assert (obs_ctl === e.ctl) else begin
        n_fail++;
        $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs_ctl, e.ctl);
      end
      n_assert++;
      assert (state_out === e.st) else begin
        n_fail++;
        $error("FAIL %s state observed=%0d expected=%0d", e.tag, state_out, e.st);
      end
      n_assert++;
      assert (stall_count === e.sc) else begin
        n_fail++;
        $error("FAIL %s stall_count observed=%0d expected=%0d", e.tag, stall_count, e.sc);
      end
      n_assert++;
      assert (mc_timeout === e.to) else begin
        n_fail++;
        $error("FAIL %s mc_timeout observed=%b expected=%b", e.tag, mc_timeout, e.to);
      end
    end
  endtask

  // One cycle: queue expectation for the inputs currently driven, check, then advance.
  task automatic step(input string tag, input logic [8:0] ctl, input logic [1:0] st);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.st = st; e.sc = sc_model; e.to = to_model;
    q.push_back(e);
    #1;
    check_out();
    if ((st == 2'd1 || st == 2'd2) && !ctl[8] && (sc_model != '1)) sc_model = sc_model + 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_ins();
    rst = 1'b1;
    step("rst_hold", C_BOOT, 2'd0);
    rst = 1'b0;
    step("boot", C_BOOT, 2'd0);
    step("run_idle", C_RUN, 2'd1);

    // Load-use hazards
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    step("lu_rs2", C_LU, 2'd1);
    clear_ins();
    step("after_lu", C_RUN, 2'd1);
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    step("lu_x0", C_RUN, 2'd1);
    ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; id_rs2 = 5'd3;
    step("lu_rs1", C_LU, 2'd1);
    id_uses_rs1 = 1'b0;
    step("lu_rs1_unused", C_RUN, 2'd1);
    ex_is_load = 1'b0; id_uses_rs1 = 1'b1;
    step("no_load", C_RUN, 2'd1);

    // Priority: branch over load-use, mem_stall over branch
    ex_is_load = 1'b1; branch_taken = 1'b1;
    step("br_over_lu", C_BR, 2'd1);
    mem_stall = 1'b1;
    step("mem_over_br", C_MEM, 2'd1);
    clear_ins();
    step("run_after_mem", C_RUN, 2'd1);

    // Multi-cycle op: same-cycle done is a normal advance
    mc_start = 1'b1; mc_done = 1'b1;
    step("mc_same_cycle", C_RUN, 2'd1);
    mc_done = 1'b0;
    step("mc_enter", C_MC, 2'd1);
    step("mc_wait1", C_MC, 2'd2);
    branch_taken = 1'b1; halt_req = 1'b1;
    ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
    step("mc_ignore", C_MC, 2'd2);
    clear_ins(); mc_start = 1'b1;
    step("mc_wait3", C_MC, 2'd2);
    mc_done = 1'b1;
    step("mc_done", C_RUN, 2'd2);
    clear_ins();
    step("mc_exit", C_RUN, 2'd1);

    // Done arriving exactly at the watchdog limit wins over the timeout
    mc_start = 1'b1;
    step("mcb_enter", C_MC, 2'd1);
    for (int k = 1; k < TB_MC_MAX; k++) step("mcb_wait", C_MC, 2'd2);
    mc_done = 1'b1;
    step("mcb_done_at_limit", C_RUN, 2'd2);
    clear_ins();
    step("mcb_exit", C_RUN, 2'd1);

    // Watchdog with a mem stall in the middle: count must freeze during the stall
    mc_start = 1'b1;
    step("wd_enter", C_MC, 2'd1);
    for (int k = 1; k < TB_MC_MAX; k++) begin
      step("wd_wait", C_MC, 2'd2);
      if (k == 2) begin
        mem_stall = 1'b1;
        step("wd_mem1", C_MEM, 2'd2);
        step("wd_mem2", C_MEM, 2'd2);
        mem_stall = 1'b0;
      end
    end
    mc_start = 1'b0;
    step("wd_fire", C_RUN, 2'd2);
    to_model = 1'b1;
    step("wd_sticky1", C_RUN, 2'd1);
    step("wd_sticky2", C_RUN, 2'd1);

    // Debug halt
    ex_is_load = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_uses_rs1 = 1'b1; halt_req = 1'b1;
    step("lu_over_halt", C_LU, 2'd1);
    ex_is_load = 1'b0;
    step("halt_enter", C_FRZ, 2'd1);
    step("halted_held", C_FRZ, 2'd3);
    halt_req = 1'b0;
    step("halted_idle", C_FRZ, 2'd3);
    resume = 1'b1;
    step("resume", C_FRZ, 2'd3);
    resume = 1'b0;
    step("resumed", C_RUN, 2'd1);
    resume = 1'b1;
    step("resume_in_run", C_RUN, 2'd1);
    resume = 1'b0; halt_req = 1'b1;
    step("halt2_enter", C_FRZ, 2'd1);
    step("halt2", C_FRZ, 2'd3);
    resume = 1'b1;
    step("resume_held_halt", C_FRZ, 2'd3);
    resume = 1'b0;
    step("halt_reenter", C_FRZ, 2'd1);
    step("halt3", C_FRZ, 2'd3);
    halt_req = 1'b0; resume = 1'b1;
    step("resume2", C_FRZ, 2'd3);
    resume = 1'b0;
    step("resumed2", C_RUN, 2'd1);

    // Asynchronous reset in the middle of MC_WAIT
    mc_start = 1'b1;
    step("mcr_enter", C_MC, 2'd1);
    step("mcr_wait", C_MC, 2'd2);
    rst = 1'b1;
    sc_model = '0; to_model = 1'b0;
    step("rst_mid_mc", C_BOOT, 2'd0);
    clear_ins();
    rst = 1'b0;
    step("reboot", C_BOOT, 2'd0);
    step("rerun", C_RUN, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the enable and flush inputs of the four inter-stage latches (s1_s2, s2_s3, s3_s4, s4_s5) and the PC update enable. It resolves the following events into one consistent per-cycle control vector:
- memory stalls
- taken branches
- multi-cycle EX operations
- load-use hazards
- debug halt

Parameters:
MC_MAX_CYCLES, 34, watchdog limit in cycles for a multi-cycle EX operation; must be >= 1.
STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
id_rs1  in  5  rs1 index of instruction in ID (s1_s2 output)
id_rs2  in  5  rs2 index of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd of instruction in EX (s2_s3 output)
ex_is_load  in  1  EX instruction is a load
branch_taken  in  1  branch/jump resolved taken in EX this cycle
mc_start  in  1  EX instruction is a multi-cycle op (mul/div), level
mc_done  in  1  multi-cycle unit result valid, one-cycle pulse
mem_stall  in  1  stage 4 memory access not complete
halt_req  in  1  debug halt request, level
resume  in  1  debug resume, pulse
pc_en  out  1  PC register update enable
en_s1_s2, en_s2_s3, en_s3_s4, en_s4_s5  out  1 each  latch enables
flush_s1_s2, flush_s2_s3, flush_s3_s4, flush_s4_s5  out  1 each  latch flushes; a latch flush overrides its enable
state_out  out  2  current state: BOOT=0, RUN=1, MC_WAIT=2, HALTED=3
mc_timeout  out  1  sticky: watchdog fired
stall_count  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- Registered state: state, mc_cnt, mc_timeout, stall_count. Control outputs are combinational from the registered state plus the current inputs, so they take effect in the same cycle.
- rst high:
  - state=BOOT, mc_cnt=0, mc_timeout=0, stall_count=0.
  - Outputs therefore read pc_en=0, all en_*=0, all flush_*=1.
- BOOT: outputs as above. The state leaves BOOT on the first clock edge after rst is released, so it lasts exactly one cycle, and goes to RUN.
- RUN evaluates the conditions below in strict priority order. The first one that matches sets the outputs; anything not listed is 0.
  - 1 mem_stall:
    - flush_s4_s5=1 (bubble into WB); all other en and pc_en=0.
    - No state change; branch, mc_start and hazard are deferred because upstream is frozen.
  - 2 branch_taken:
    - pc_en=1; flush_s1_s2=1; flush_s2_s3=1; en_s3_s4=1; en_s4_s5=1.
  - 3 mc_start and not mc_done:
    - flush_s3_s4=1; en_s4_s5=1; pc_en, en_s1_s2 and en_s2_s3=0.
    - Next state MC_WAIT, mc_cnt<=1.
    - If mc_start and mc_done are high together, it is treated as a normal advance.
  - 4 load-use: ex_is_load and ex_rd!=0 and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
    - pc_en=0; en_s1_s2=0; flush_s2_s3=1; en_s3_s4=1; en_s4_s5=1.
  - 5 halt_req:
    - All en and pc_en=0, no flush; next state HALTED.
  - 6 otherwise: pc_en and all en_*=1.
- MC_WAIT:
  - mem_stall has priority and gives the same outputs as RUN case 1; mc_cnt holds.
  - Else if mc_done:
    - pc_en and all en_*=1; next state RUN.
  - Else if mc_cnt==MC_MAX_CYCLES:
    - Same outputs as mc_done; mc_timeout<=1; next state RUN.
  - Else: outputs as RUN case 3; mc_cnt+=1.
  - branch_taken, halt_req and the load-use hazard are ignored in MC_WAIT.
- HALTED:
  - All en and pc_en=0, no flush.
  - resume moves the state to RUN on the next cycle; a resume seen in any other state is ignored.
  - In RUN, a halt_req that is still held re-enters HALTED via case 5.
- stall_count increments by 1 in every RUN or MC_WAIT cycle with pc_en=0 and saturates at all-ones. BOOT and HALTED cycles are not counted.
- mc_timeout is cleared only by rst.
- Asserting rst in any state, including mid MC_WAIT, returns the block to BOOT immediately.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (BOOT/RUN/MC_WAIT/HALTED, 2-bit encoding as state_out)
  - the STALL_CNT_W default
  - the x0 register index constant (5'd0)
- One combinational sub-module, load_use_detect: inputs id_rs1/id_rs2/id_uses_*/ex_rd/ex_is_load, output hazard.

Test Plan:
- Reset then release -> one cycle with state_out=0 and all flush_*=1, then state_out=1 with pc_en=1 and all en_*=1; stall_count=0.
- RUN, ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for 1 cycle -> pc_en=0, en_s1_s2=0, flush_s2_s3=1, en_s3_s4=1; stall_count=1. Repeat with ex_rd=0 -> no stall.
- branch_taken=1 together with an active load-use hazard -> flush_s1_s2=1, flush_s2_s3=1, pc_en=1; no stall counted.
- mc_start=1, mc_done pulsed 4 cycles later -> state_out=2 for 4 cycles with flush_s3_s4=1, then the all-enable cycle and state_out=1; stall_count=4.
- mc_start=1 with MC_MAX_CYCLES=3 and no mc_done -> the forced advance fires on the 3rd cycle in MC_WAIT; mc_timeout=1 and it stays 1 until rst.
- mem_stall=1 for 2 cycles inside MC_WAIT, then mc_done -> mc_cnt frozen and flush_s4_s5=1 during the stall; the exit completes normally.
- halt_req=1 -> state_out=3 and everything frozen; resume pulse -> RUN next cycle; stall_count unchanged while HALTED.
